// File: rtl/pipe_mux.sv
// pipe_mux: registered N:1 channel mux with external select or round-robin arbitration.
// Optional taint tracking is enabled by defining PIPE_MUX_TAINT_EN.
module pipe_mux #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter int  RR_MODE  = 0,
    localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef PIPE_MUX_TAINT_EN
    ,
    input  logic [CHANNELS-1:0]       in_taint,
    input  logic                      sel_taint,
    output logic                      out_taint
`endif
);
    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_chan;
    logic             r_valid;
    logic [SELW-1:0]  w_rr_win;
    logic             w_rr_ok;
    logic [SELW-1:0]  w_win;
    logic             w_win_ok;
    logic             w_slot_free;
    logic             w_xfer;

    function automatic logic [SELW-1:0] f_wrap(input logic [SELW-1:0] p, input int k);
        int j = int'(p) + k;
        return SELW'((j >= CHANNELS) ? j - CHANNELS : j);
    endfunction

    // Round-robin search from ptr upward with wrap; scanning backwards lets the nearest requester win
    always_comb begin
        w_rr_ok  = 1'b0;
        w_rr_win = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_valid[f_wrap(r_ptr, k)]) begin
                w_rr_ok  = 1'b1;
                w_rr_win = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_slot_free = !r_valid || out_ready;
    assign w_win       = (RR_MODE != 0) ? w_rr_win : sel;
    assign w_win_ok    = (RR_MODE != 0) ? w_rr_ok : (int'(sel) < CHANNELS);
    assign w_xfer      = w_win_ok && w_slot_free && in_valid[w_win];
    assign in_ready    = (rst_n && w_win_ok && w_slot_free) ? (CHANNELS'(1) << w_win) : '0;
    assign out_data    = r_data;
    assign out_chan    = r_chan;
    assign out_valid   = r_valid;

    // Output stage: load on transfer, empty when drained with nothing new, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= in_data[int'(w_win)*WIDTH +: WIDTH];
            r_chan  <= w_win;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the winner, only when a word is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (RR_MODE != 0 && w_xfer)
            r_ptr <= (int'(w_win) == CHANNELS - 1) ? '0 : w_win + SELW'(1);
    end

`ifdef PIPE_MUX_TAINT_EN
    logic r_taint;

    // Taint travels with the data word; an externally chosen select can taint it too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_taint <= 1'b0;
        else if (w_xfer)
            r_taint <= in_taint[w_win] | (sel_taint && RR_MODE == 0);
    end

    assign out_taint = r_taint;
`endif
endmodule
